// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared arbiter definitions: FSM encoding and index-width helper.
package handshake_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter_if.sv
// Valid/ready bundle between N requesters, the arbiter and one downstream consumer.
interface handshake_rr_arbiter_if
  import handshake_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int IDXW = clog2(N);

  logic [N-1:0]       valid_i;
  logic [N-1:0]       ready_o;
  logic [N*WIDTH-1:0] data_i;
  logic [N-1:0]       last_i;
  logic               valid_o;
  logic               ready_i;
  logic [WIDTH-1:0]   data_o;
  logic               last_o;
  logic [IDXW-1:0]    src_o;

  modport master (
    output valid_i, data_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, src_o
  );

  modport slave (
    input  valid_i, data_i, last_i, ready_i,
    output ready_o, valid_o, data_o, last_o, src_o
  );

endinterface

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // Lower copy masked below ptr, upper copy whole: the lowest surviving bit is the winner.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        idx = IDXW'(i % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin N:1 valid/ready arbiter with per-packet locking and a registered output stage.
// One cycle latency, one beat per cycle; ready_o follows ready_i combinationally.
module handshake_rr_arbiter
  import handshake_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input logic                 clk,
  input logic                 rstn,
  handshake_rr_arbiter_if.slave bus
);

  localparam int IDXW = clog2(N);

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] sel;
  logic [IDXW-1:0] next_ptr;
  logic            pick_any;
  logic            owner_valid;
  logic            sel_valid;
  logic            load;
  logic            xfer;
  logic            sel_last;
  logic [WIDTH-1:0] sel_data;
  logic [N-1:0]    ready;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req (bus.valid_i),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign load      = !bus.valid_o || bus.ready_i;
  assign sel       = (state == ST_LOCK) ? owner : pick_idx;
  assign sel_valid = (state == ST_LOCK) ? owner_valid : pick_any;
  // Held low during reset so no requester sees a grant that the output stage cannot take.
  assign xfer      = rstn && load && sel_valid;
  assign next_ptr  = (sel == IDXW'(N - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    ready       = '0;
    sel_data    = '0;
    sel_last    = 1'b0;
    owner_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (IDXW'(k) == owner) owner_valid = bus.valid_i[k];
      if (IDXW'(k) == sel) begin
        ready[k] = xfer;
        sel_data = bus.data_i[k*WIDTH +: WIDTH];
        sel_last = bus.last_i[k];
      end
    end
  end

  assign bus.ready_o = ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
    end else if (xfer) begin
      case (state)
        ST_IDLE: begin
          if (!sel_last) begin
            state <= ST_LOCK;
            owner <= sel;
          end
        end
        ST_LOCK: begin
          if (sel_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Fairness advances per packet, so only the closing beat moves the pointer.
      if (sel_last) ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
      bus.last_o  <= 1'b0;
      bus.src_o   <= '0;
    end else if (load) begin
      bus.valid_o <= xfer;
      if (xfer) begin
        bus.data_o <= sel_data;
        bus.last_o <= sel_last;
        bus.src_o  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed and random checks of handshake_rr_arbiter against a cycle-level reference model.
module tb_handshake_rr_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  handshake_rr_arbiter_if #(.WIDTH(W), .N(N)) bus ();
  handshake_rr_arbiter #(.WIDTH(W), .N(N)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  handshake_rr_arbiter_if #(.WIDTH(8), .N(3)) bus3 ();
  handshake_rr_arbiter #(.WIDTH(8), .N(3)) dut3 (.clk(clk), .rstn(rstn), .bus(bus3.slave));

  int total = 0;
  int bad = 0;

  // Reference model state: lock flag, owner, rotation pointer, output register.
  bit        m_lock;
  int        m_owner, m_ptr, m_src;
  bit        m_vo, m_lo;
  logic [W-1:0] m_do;
  int        in_cnt[N];
  int        out_cnt[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_owner = 0; m_ptr = 0; m_src = 0;
    m_vo = 0; m_lo = 0; m_do = '0;
    for (int k = 0; k < N; k++) begin
      in_cnt[k] = 0;
      out_cnt[k] = 0;
    end
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic tick(output logic [N-1:0] xm);
    bit load, sv, lastb;
    int sel;
    logic [N-1:0] er;
    load = !m_vo || bus.ready_i;
    sel = 0;
    sv = 0;
    if (m_lock) begin
      sel = m_owner;
      sv = bus.valid_i[m_owner];
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!sv && bus.valid_i[(m_ptr + i) % N]) begin
          sel = (m_ptr + i) % N;
          sv = 1;
        end
      end
    end
    er = (load && sv) ? (N'(1) << sel) : '0;
    #1;
    chk("ready_o", bus.ready_o, er);
    chk("valid_o", bus.valid_o, m_vo);
    if (m_vo) begin
      chk("data_o", bus.data_o, m_do);
      chk("last_o", bus.last_o, m_lo);
      chk("src_o", bus.src_o, m_src);
    end
    if (bus.valid_o && bus.ready_i) out_cnt[bus.src_o]++;
    xm = er;
    @(posedge clk);
    if (load) begin
      m_vo = sv;
      if (sv) begin
        lastb = bus.last_i[sel];
        m_do = bus.data_i[sel*W +: W];
        m_lo = lastb;
        m_src = sel;
        in_cnt[sel]++;
        if (!m_lock && !lastb) begin
          m_lock = 1;
          m_owner = sel;
        end else if (m_lock && lastb) begin
          m_lock = 0;
        end
        if (lastb) m_ptr = (sel + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain_chk(input string tag);
    logic [N-1:0] xm;
    bus.valid_i = '0;
    bus.ready_i = 1'b1;
    tick(xm);
    tick(xm);
    for (int k = 0; k < N; k++) chk(tag, out_cnt[k], in_cnt[k]);
  endtask

  initial begin
    logic [N-1:0] xm;
    logic [N-1:0] rv;
    int rbeat[N];
    int rlen[N];
    int rseq[N];
    int exp_src[5];

    exp_src = '{0, 1, 2, 3, 0};
    bus3.valid_i = '0; bus3.data_i = '0; bus3.last_i = '0; bus3.ready_i = 1'b1;

    // Reset with every requester offering a 1-beat packet
    bus.ready_i = 1'b1;
    bus.valid_i = '1;
    bus.last_i = '1;
    for (int k = 0; k < N; k++) bus.data_i[k*W +: W] = W'(32'h10 * k);
    model_reset();
    #12;
    chk("rst_valid_o", bus.valid_o, 1'b0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_last_o", bus.last_o, 1'b0);
    chk("rst_src_o", bus.src_o, 0);
    chk("rst_ready_o", bus.ready_o, 0);
    chk("rst3_valid_o", bus3.valid_o, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(xm);
      chk("rr_valid", bus.valid_o, 1'b1);
      chk("rr_src", bus.src_o, exp_src[i]);
      chk("rr_data", bus.data_o, 32'h10 * exp_src[i]);
    end

    // Packet lock: requester 2 holds the channel while requester 0 waits
    bus.valid_i = 4'b0101;
    bus.data_i[2*W +: W] = 32'hA0; bus.last_i[2] = 1'b0;
    bus.data_i[0 +: W] = 32'h55;   bus.last_i[0] = 1'b1;
    tick(xm);
    chk("lock_b0", bus.data_o, 32'hA0);
    chk("lock_src0", bus.src_o, 2);
    bus.data_i[2*W +: W] = 32'hA1;
    tick(xm);
    chk("lock_b1", bus.data_o, 32'hA1);
    bus.data_i[2*W +: W] = 32'hA2; bus.last_i[2] = 1'b1;
    tick(xm);
    chk("lock_b2", bus.data_o, 32'hA2);
    chk("lock_last", bus.last_o, 1'b1);
    bus.valid_i[2] = 1'b0;
    tick(xm);
    chk("lock_next", bus.data_o, 32'h55);
    chk("lock_next_src", bus.src_o, 0);

    // Backpressure: output stage holds for 3 stalled cycles
    bus.valid_i = 4'b1010;
    bus.data_i[1*W +: W] = 32'h11; bus.last_i[1] = 1'b1;
    bus.data_i[3*W +: W] = 32'h33; bus.last_i[3] = 1'b1;
    tick(xm);
    chk("bp_first", bus.data_o, 32'h11);
    bus.valid_i[1] = 1'b0;
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(xm);
      chk("bp_hold", bus.data_o, 32'h11);
      chk("bp_no_ready", bus.ready_o, 0);
    end
    bus.ready_i = 1'b1;
    tick(xm);
    chk("bp_release", bus.data_o, 32'h33);
    chk("bp_release_src", bus.src_o, 3);
    bus.valid_i[3] = 1'b0;
    drain_chk("bp_scoreboard");

    // Owner bubble: requester 0 pauses mid-packet, requester 3 must not interleave
    bus.valid_i = 4'b1001;
    bus.data_i[0 +: W] = 32'hB0; bus.last_i[0] = 1'b0;
    bus.data_i[3*W +: W] = 32'hCC; bus.last_i[3] = 1'b1;
    tick(xm);
    chk("bub_b0", bus.data_o, 32'hB0);
    bus.valid_i[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(xm);
      chk("bub_gap", bus.valid_o, 1'b0);
    end
    bus.valid_i[0] = 1'b1; bus.data_i[0 +: W] = 32'hB1;
    tick(xm);
    chk("bub_b1", bus.data_o, 32'hB1);
    bus.data_i[0 +: W] = 32'hB2; bus.last_i[0] = 1'b1;
    tick(xm);
    chk("bub_b2", bus.data_o, 32'hB2);
    bus.valid_i[0] = 1'b0;
    tick(xm);
    chk("bub_after", bus.data_o, 32'hCC);
    chk("bub_after_src", bus.src_o, 3);
    bus.valid_i = '0;
    tick(xm);

    // Reset asserted between edges during a locked packet
    bus.valid_i = 4'b0010;
    bus.data_i[1*W +: W] = 32'hC0; bus.last_i[1] = 1'b0;
    tick(xm);
    chk("mid_pre_valid", bus.valid_o, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_valid_o", bus.valid_o, 1'b0);
    chk("mid_data_o", bus.data_o, 0);
    chk("mid_src_o", bus.src_o, 0);
    chk("mid_ready_o", bus.ready_o, 0);
    bus.valid_i = 4'b0111;
    bus.last_i = '1;
    for (int k = 0; k < N; k++) bus.data_i[k*W +: W] = W'(32'hD0 + k);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    tick(xm);
    chk("mid_restart_src", bus.src_o, 0);
    chk("mid_restart_data", bus.data_o, 32'hD0);
    bus.valid_i = '0;
    tick(xm);

    // Random packets, bubbles and backpressure against the model
    rv = '0;
    for (int k = 0; k < N; k++) begin
      rbeat[k] = 0;
      rseq[k] = 0;
      rlen[k] = $urandom_range(1, 4);
    end
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!rv[k] && $urandom_range(0, 2) == 0) begin
          rv[k] = 1'b1;
          bus.data_i[k*W +: W] = {8'(k), 8'(rseq[k]), 8'(rbeat[k]), 8'h5A};
          bus.last_i[k] = (rbeat[k] == rlen[k] - 1);
        end
      end
      bus.valid_i = rv;
      bus.ready_i = ($urandom_range(0, 3) != 0);
      tick(xm);
      for (int k = 0; k < N; k++) begin
        if (xm[k]) begin
          rv[k] = 1'b0;
          if (bus.last_i[k]) begin
            rbeat[k] = 0;
            rseq[k]++;
            rlen[k] = $urandom_range(1, 4);
          end else begin
            rbeat[k]++;
          end
        end
      end
    end
    drain_chk("rand_scoreboard");

    // N=3: pointer at 2 serves 2 then wraps to 0
    bus3.valid_i = 3'b010;
    bus3.last_i = 3'b111;
    bus3.data_i[8 +: 8] = 8'h01;
    @(posedge clk);
    @(negedge clk);
    bus3.valid_i = 3'b101;
    bus3.data_i[0 +: 8] = 8'h0A;
    bus3.data_i[16 +: 8] = 8'h02;
    #1;
    chk("n3_ready_first", bus3.ready_o, 3'b100);
    @(posedge clk);
    @(negedge clk);
    chk("n3_src_first", bus3.src_o, 2);
    chk("n3_data_first", bus3.data_o, 8'h02);
    bus3.valid_i = 3'b001;
    #1;
    chk("n3_ready_wrap", bus3.ready_o, 3'b001);
    @(posedge clk);
    @(negedge clk);
    chk("n3_src_wrap", bus3.src_o, 0);
    chk("n3_data_wrap", bus3.data_o, 8'h0A);
    bus3.valid_i = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
